// File: rtl/mpmc11_burst_cmd_gen.sv
// mpmc11 burst command generator: issues len+1 app commands per request
// and, for writes, feeds the write-data FIFO with a bounded data lead.
module mpmc11_burst_cmd_gen #(
  parameter int ADDR_W        = 29,
  parameter int ADDR_INC      = 8,
  parameter int BEATS_PER_CMD = 2,
  parameter int MAX_LEAD      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } state_t;

  state_t            state;
  logic [7:0]        len;
  logic [8:0]        cmd_cnt;
  logic [8:0]        data_cmds;
  logic [1:0]        cmdbeat;
  logic [ADDR_W-1:0] addr;

  logic [8:0] len9;
  logic [9:0] lead_lim;
  logic       cmd_acc;
  logic       beat_acc;
  logic       end_beat;
  logic       last_cmd;
  logic       data_all;

  assign len9     = {1'b0, len};
  assign lead_lim = {1'b0, cmd_cnt} + 10'(MAX_LEAD);
  assign end_beat = (cmdbeat == 2'(BEATS_PER_CMD - 1));
  assign last_cmd = (cmd_cnt == len9);
  assign data_all = (data_cmds == 9'(len9 + 9'd1));

  // Strobes depend only on state/counters (plus wd_valid for wren).
  always_comb begin
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    unique case (state)
      RD: app_en = 1'b1;
      WR: begin
        app_en       = (data_cmds > cmd_cnt) && (cmd_cnt <= len9);
        app_wdf_wren = wd_valid
                       && ({1'b0, data_cmds} < lead_lim)
                       && (data_cmds <= len9);
      end
      default: ;
    endcase
  end

  assign app_cmd     = (state == WR) ? 3'b000 : 3'b001;
  assign app_addr    = addr;
  assign app_wdf_end = end_beat;
  assign cmd_acc     = app_en && app_rdy;
  assign beat_acc    = app_wdf_wren && app_wdf_rdy;
  assign wd_ready    = beat_acc;
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      len       <= '0;
      cmd_cnt   <= '0;
      data_cmds <= '0;
      cmdbeat   <= '0;
      addr      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            len       <= req_len;
            addr      <= req_addr;
            cmd_cnt   <= '0;
            data_cmds <= '0;
            cmdbeat   <= '0;
            state     <= req_we ? WR : RD;
          end
        end
        RD: begin
          if (cmd_acc) begin
            addr    <= addr + ADDR_W'(ADDR_INC);
            cmd_cnt <= cmd_cnt + 9'd1;
            if (last_cmd) state <= FIN;
          end
        end
        WR: begin
          if (cmd_acc) begin
            addr    <= addr + ADDR_W'(ADDR_INC);
            cmd_cnt <= cmd_cnt + 9'd1;
          end
          if (beat_acc) begin
            if (end_beat) begin
              cmdbeat   <= '0;
              data_cmds <= data_cmds + 9'd1;
            end else begin
              cmdbeat <= cmdbeat + 2'd1;
            end
          end
          if (cmd_acc && last_cmd && data_all) state <= FIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc11_burst_cmd_gen.sv
// Bench for mpmc11_burst_cmd_gen: directed and random bursts checked
// against a transaction-count reference model.
module tb_mpmc11_burst_cmd_gen;

  localparam int AW   = 29;
  localparam int AINC = 8;
  localparam int BPC  = 2;
  localparam int ML   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_len = '0;
  logic          wd_valid = 1'b0;
  logic          wd_ready;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy = 1'b0;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy = 1'b0;
  logic          busy;
  logic          done;

  int errs = 0;
  int checks = 0;
  int stall_beats;
  int beats_total;

  mpmc11_burst_cmd_gen #(
    .ADDR_W(AW), .ADDR_INC(AINC),
    .BEATS_PER_CMD(BPC), .MAX_LEAD(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One full burst; the model tracks accepted commands/beats only.
  task automatic burst(input logic we, input logic [AW-1:0] a,
                       input logic [7:0] l, input int rdy_pct,
                       input int st_lo, input int st_hi,
                       input int wdf_mode, input int val_pct);
    int cmds, dcmds, beat, lim, n;
    bit fin, complete, acc_c, acc_b, e_wren, e_en;
    logic [AW-1:0] ea;
    n = int'(l) + 1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; wd_valid = 1'b0;
    #1;
    chk("acc_ready", req_ready, 1);
    chk("acc_busy", busy, 0);
    chk("acc_en", app_en, 0);
    chk("acc_wren", app_wdf_wren, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom);
    req_addr = AW'($urandom); req_len = 8'($urandom);
    cmds = 0; dcmds = 0; beat = 0; fin = 0;
    stall_beats = 0; beats_total = 0;
    lim = n * (BPC + 1) * 30 + 200;
    for (int cyc = 0; cyc < lim && !fin; cyc++) begin
      @(negedge clk);
      app_rdy = (cyc >= st_lo && cyc <= st_hi) ? 1'b0
              : 1'($urandom_range(99) < rdy_pct);
      case (wdf_mode)
        0: app_wdf_rdy = 1'b1;
        1: app_wdf_rdy = 1'(cyc % 2 == 0);
        default: app_wdf_rdy = 1'($urandom_range(1));
      endcase
      wd_valid = 1'($urandom_range(99) < val_pct);
      #1;
      complete = (cmds == n) && (!we || dcmds == n);
      acc_c = 0; acc_b = 0;
      if (complete) begin
        chk("done", done, 1);
        chk("fin_en", app_en, 0);
        chk("fin_wren", app_wdf_wren, 0);
        chk("fin_busy", busy, 1);
        chk("fin_rdy", req_ready, 0);
        fin = 1;
      end else begin
        ea = a + AW'(cmds * AINC);
        chk("run_done", done, 0);
        chk("run_busy", busy, 1);
        chk("run_rdy", req_ready, 0);
        if (!we) begin
          chk("rd_en", app_en, 1);
          chk("rd_cmd", app_cmd, 1);
          chk("rd_addr", app_addr, ea);
          chk("rd_wren", app_wdf_wren, 0);
          chk("rd_wdrdy", wd_ready, 0);
        end else begin
          e_wren = wd_valid && (dcmds < cmds + ML) && (dcmds <= int'(l));
          e_en = (dcmds > cmds) && (cmds <= int'(l));
          chk("wr_wren", app_wdf_wren, e_wren);
          chk("wr_wdrdy", wd_ready, e_wren && app_wdf_rdy);
          chk("wr_en", app_en, e_en);
          if (e_en) begin
            chk("wr_cmd", app_cmd, 0);
            chk("wr_addr", app_addr, ea);
          end
          if (e_wren) chk("wr_end", app_wdf_end, beat == BPC - 1);
        end
        acc_c = app_en && app_rdy;
        acc_b = app_wdf_wren && app_wdf_rdy;
      end
      @(posedge clk);
      if (acc_c) cmds++;
      if (acc_b) begin
        beats_total++;
        if (cyc <= st_hi) stall_beats++;
        beat++;
        if (beat == BPC) begin
          beat = 0;
          dcmds++;
        end
      end
    end
    chk("timeout", fin, 1);
    if (!fin) pulse_reset();
    @(negedge clk);
    app_rdy = 1'b1; wd_valid = 1'b1; app_wdf_rdy = 1'b1;
    #1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_rdy", req_ready, 1);
    chk("post_en", app_en, 0);
    chk("post_wren", app_wdf_wren, 0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rdy", req_ready, 1);
    chk("rst_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd", app_cmd, 1);
    chk("rst_addr", app_addr, 0);
    rst = 1'b1;

    burst(0, AW'('h100), 8'd3, 100, -1, -1, 0, 100);
    burst(0, AW'('h100), 8'd1, 100, 2, 4, 0, 100);
    burst(1, AW'('h100), 8'd1, 100, -1, -1, 0, 100);
    chk("wr_beats", beats_total, 2 * BPC);
    burst(1, AW'('h100), 8'd5, 100, 0, 9, 0, 100);
    chk("lead_beats", stall_beats, ML * BPC);
    chk("lead_total", beats_total, 6 * BPC);
    burst(1, AW'('h40), 8'd4, 100, -1, -1, 1, 100);

    // Reset in the middle of a write burst, after its first command.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'('h200); req_len = 8'd3;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; wd_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #1 seen = app_en && app_rdy;
      @(posedge clk);
    end
    chk("mid_cmd_seen", seen, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_en", app_en, 0);
    chk("mid_wren", app_wdf_wren, 0);
    chk("mid_wdrdy", wd_ready, 0);
    chk("mid_rdy", req_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_addr", app_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    burst(0, AW'('h300), 8'd2, 100, -1, -1, 0, 100);

    burst(0, AW'((1 << AW) - 16), 8'd3, 100, -1, -1, 0, 100);
    burst(1, AW'((1 << AW) - 8), 8'd2, 70, -1, -1, 2, 80);

    for (int k = 0; k < 12; k++) begin
      burst(1'($urandom), AW'($urandom), 8'($urandom_range(20)),
            $urandom_range(100, 30), -1, -1, 2,
            $urandom_range(100, 30));
    end

    burst(1, AW'($urandom), 8'd255, 100, -1, -1, 0, 100);
    chk("max_beats", beats_total, 256 * BPC);
    burst(0, AW'($urandom), 8'd255, 90, -1, -1, 0, 100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
